axi_lite_sram_responder: RTL



---
 rtl/axi_lite_sram_responder_pkg.sv | 28 ++
 rtl/sram_byte_array.sv | 29 ++
 rtl/axi_lite_sram_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_sram_responder_pkg.sv
// rtl/axi_lite_sram_responder_pkg.sv - shared types and address decode for the SRAM responder
package axi_lite_sram_responder_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  // Word-granular compare so BASE + 4*DEPTH never has to be formed (it can overflow 32 bits).
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] depth);
    return (addr >= base) && (((addr - base) >> 2) < depth);
  endfunction

endpackage

// File: rtl/sram_byte_array.sv
// rtl/sram_byte_array.sv - DEPTH x 32 storage, combinational read, clocked byte-enabled write
module sram_byte_array #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [31:0]      o_rd_data,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [31:0]      i_wr_data,
  input  logic [3:0]       i_wr_strb
);

  logic [31:0] r_mem [DEPTH];

  assign o_rd_data = r_mem[i_rd_idx];

  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i_wr_strb[i]) begin
          r_mem[i_wr_idx][8*i +: 8] <= i_wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi_lite_sram_responder.sv
// rtl/axi_lite_sram_responder.sv - AXI4-Lite style data-memory target with per-channel latency
module axi_lite_sram_responder
  import axi_lite_sram_responder_pkg::*;
#(
  parameter int          DEPTH = 4096,
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          R_LAT = 1,
  parameter int          W_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int         IDX_W   = $clog2(DEPTH);
  localparam logic [3:0] R_LAT_C = 4'(R_LAT);
  localparam logic [3:0] W_LAT_C = 4'(W_LAT);

  r_state_t    r_rstate;
  logic [3:0]  r_rcnt;
  logic [31:0] r_araddr;
  logic [31:0] r_rdata;
  resp_t       r_rresp;

  w_state_t    r_wstate;
  logic [3:0]  r_wcnt;
  logic        r_aw_held;
  logic        r_w_held;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  resp_t       r_bresp;

  logic             w_ar_fire;
  logic             w_rd_lookup;
  logic [31:0]      w_rd_addr;
  logic [31:0]      w_rd_off;
  logic             w_rd_ok;
  logic [31:0]      w_rd_word;
  logic             w_aw_fire;
  logic             w_w_fire;
  logic             w_both;
  logic             w_commit;
  logic [31:0]      w_cur_awaddr;
  logic [31:0]      w_cur_wdata;
  logic [3:0]       w_cur_wstrb;
  logic [31:0]      w_wr_off;
  logic             w_wr_ok;
  logic             w_unused;

  assign arready = (r_rstate == R_IDLE);
  assign rvalid  = (r_rstate == R_RESP);
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

  assign awready = (r_wstate == W_IDLE) && !r_aw_held;
  assign wready  = (r_wstate == W_IDLE) && !r_w_held;
  assign bvalid  = (r_wstate == W_RESP);
  assign bresp   = r_bresp;

  // With zero read latency the lookup happens on the handshake edge, before araddr is latched.
  assign w_ar_fire   = arvalid && arready;
  assign w_rd_addr   = (r_rstate == R_IDLE) ? araddr : r_araddr;
  assign w_rd_off    = w_rd_addr - BASE;
  assign w_rd_ok     = addr_in_range(w_rd_addr, BASE, 32'(DEPTH));
  assign w_rd_lookup = ((r_rstate == R_IDLE) && w_ar_fire && (R_LAT_C == 4'd0)) ||
                       ((r_rstate == R_WAIT) && (r_rcnt <= 4'd1));

  assign w_aw_fire    = awvalid && awready;
  assign w_w_fire     = wvalid && wready;
  assign w_cur_awaddr = r_aw_held ? r_awaddr : awaddr;
  assign w_cur_wdata  = r_w_held ? r_wdata : wdata;
  assign w_cur_wstrb  = r_w_held ? r_wstrb : wstrb;
  assign w_both       = (r_wstate == W_IDLE) && (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);
  assign w_commit     = (w_both && (W_LAT_C == 4'd0)) ||
                        ((r_wstate == W_WAIT) && (r_wcnt <= 4'd1));
  assign w_wr_off     = w_cur_awaddr - BASE;
  assign w_wr_ok      = addr_in_range(w_cur_awaddr, BASE, 32'(DEPTH));

  assign w_unused = ^{w_rd_off[31:IDX_W+2], w_rd_off[1:0], w_wr_off[31:IDX_W+2], w_wr_off[1:0]};

  sram_byte_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clock     (clock),
    .i_rd_idx  (w_rd_off[IDX_W+1:2]),
    .o_rd_data (w_rd_word),
    .i_wr_en   (w_commit && w_wr_ok),
    .i_wr_idx  (w_wr_off[IDX_W+1:2]),
    .i_wr_data (w_cur_wdata),
    .i_wr_strb (w_cur_wstrb)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rstate <= R_IDLE;
      r_rcnt   <= 4'd0;
      r_araddr <= 32'd0;
      r_rdata  <= 32'd0;
      r_rresp  <= OKAY;
    end else begin
      if (w_rd_lookup) begin
        r_rdata <= w_rd_ok ? w_rd_word : 32'd0;
        r_rresp <= w_rd_ok ? OKAY : DECERR;
      end
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_fire) begin
            r_araddr <= araddr;
            r_rcnt   <= R_LAT_C;
            if (R_LAT_C == 4'd0) r_rstate <= R_RESP;
            else                 r_rstate <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_rcnt <= 4'd1) begin
            r_rcnt   <= 4'd0;
            r_rstate <= R_RESP;
          end else begin
            r_rcnt <= r_rcnt - 4'd1;
          end
        end
        R_RESP: begin
          if (rready) r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wstate  <= W_IDLE;
      r_wcnt    <= 4'd0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= 32'd0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'd0;
      r_bresp   <= OKAY;
    end else begin
      if (w_aw_fire) begin
        r_awaddr  <= awaddr;
        r_aw_held <= 1'b1;
      end
      if (w_w_fire) begin
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
        r_w_held <= 1'b1;
      end
      if (w_commit) r_bresp <= w_wr_ok ? OKAY : DECERR;
      case (r_wstate)
        W_IDLE: begin
          if (w_both) begin
            r_wcnt <= W_LAT_C;
            if (W_LAT_C == 4'd0) r_wstate <= W_RESP;
            else                 r_wstate <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (r_wcnt <= 4'd1) begin
            r_wcnt   <= 4'd0;
            r_wstate <= W_RESP;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

endmodule
